// File: rtl/lcd_text_pkg.sv
// Text-mode geometry, control-byte values and FSM encoding shared by the text
// controller and the ST7920 refresher.
package lcd_text_pkg;

    localparam int COLS      = 16;
    localparam int ROWS      = 4;
    localparam int RAM_DEPTH = COLS * ROWS;

    localparam logic [3:0] LAST_COL = 4'd15;
    localparam logic [1:0] LAST_ROW = 2'd3;
    localparam logic [5:0] LAST_IDX = 6'd63;
    localparam logic [5:0] ROW1_IDX = 6'd16;
    localparam logic [5:0] ROW3_IDX = 6'd48;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_SCR_RD    = 3'd2,
        ST_SCR_WR    = 3'd3,
        ST_SCR_BLANK = 3'd4
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_ram_dp.sv
// 64x8 character RAM: port A is the refresher's read-only port, port B is the
// controller's read/write port. Both reads are registered and return old data on a write.
module text_ram_dp (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] addr_a,
    output logic [7:0] dout_a,
    input  logic [5:0] addr_b,
    input  logic       we_b,
    input  logic [7:0] din_b,
    output logic [7:0] dout_b
);

    logic [7:0] mem [64];

    always_ff @(posedge clk) begin
        if (we_b) begin
            mem[addr_b] <= din_b;
        end
        dout_b <= mem[addr_b];
    end

    // Only the output register is reset; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a <= 8'h00;
        end else begin
            dout_a <= mem[addr_a];
        end
    end

endmodule

// File: rtl/lcd_text_ctrl.sv
// Turns a character stream into writes to the 4x16 text RAM, tracks the cursor,
// and runs the multi-cycle clear and scroll-up sequences.
module lcd_text_ctrl
    import lcd_text_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR  = 8'h20,
    parameter bit         INIT_CLEAR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] disp_addr,
    output logic [7:0] disp_data,
    input  logic       ch_valid,
    input  logic [7:0] ch_data,
    output logic       ch_ready,
    output logic [1:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       busy,
    output state_t     dbg_state
);

    state_t     state;
    logic [5:0] idx;
    logic [1:0] row;
    logic [3:0] col;

    logic       we_b;
    logic [5:0] addr_b;
    logic [7:0] din_b;
    logic [7:0] dout_b;

    // Handshake: a byte transfers on a rising clk edge where ch_valid && ch_ready;
    // ch_ready is high only in IDLE, and the producer keeps ch_valid/ch_data stable until then.
    logic xfer;
    assign xfer     = ch_valid && ch_ready;
    assign ch_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    assign cursor_row = row;
    assign cursor_col = col;
    assign dbg_state  = state;

    always_comb begin
        we_b   = 1'b0;
        addr_b = {row, col};
        din_b  = FILL_CHAR;
        case (state)
            ST_IDLE: begin
                if (xfer && is_printable(ch_data)) begin
                    we_b  = 1'b1;
                    din_b = ch_data;
                end else if (xfer && ch_data == BS && col != 4'd0) begin
                    we_b   = 1'b1;
                    addr_b = {row, col - 4'd1};
                end
            end
            ST_CLEAR, ST_SCR_BLANK: begin
                we_b   = 1'b1;
                addr_b = idx;
            end
            ST_SCR_RD: addr_b = idx;
            ST_SCR_WR: begin
                we_b   = 1'b1;
                addr_b = idx - ROW1_IDX;
                din_b  = dout_b;
            end
            default: ;
        endcase
        if (rst) begin
            we_b = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
            idx   <= 6'd0;
            row   <= 2'd0;
            col   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        if (is_printable(ch_data)) begin
                            if (col != LAST_COL) begin
                                col <= col + 4'd1;
                            end else begin
                                col <= 4'd0;
                                if (row != LAST_ROW) begin
                                    row <= row + 2'd1;
                                end else begin
                                    state <= ST_SCR_RD;
                                    idx   <= ROW1_IDX;
                                end
                            end
                        end else begin
                            case (ch_data)
                                CR: col <= 4'd0;
                                LF: begin
                                    col <= 4'd0;
                                    if (row != LAST_ROW) begin
                                        row <= row + 2'd1;
                                    end else begin
                                        state <= ST_SCR_RD;
                                        idx   <= ROW1_IDX;
                                    end
                                end
                                BS: if (col != 4'd0) col <= col - 4'd1;
                                FF: begin
                                    state <= ST_CLEAR;
                                    idx   <= 6'd0;
                                    row   <= 2'd0;
                                    col   <= 4'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_CLEAR, ST_SCR_BLANK: begin
                    if (idx == LAST_IDX) begin
                        idx   <= 6'd0;
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                ST_SCR_RD: state <= ST_SCR_WR;
                // The byte read in SCR_RD lands one row up; the last row is then blanked.
                ST_SCR_WR: begin
                    if (idx == LAST_IDX) begin
                        idx   <= ROW3_IDX;
                        state <= ST_SCR_BLANK;
                    end else begin
                        idx   <= idx + 6'd1;
                        state <= ST_SCR_RD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    text_ram_dp u_ram (
        .clk    (clk),
        .rst    (rst),
        .addr_a (disp_addr),
        .dout_a (disp_data),
        .addr_b (addr_b),
        .we_b   (we_b),
        .din_b  (din_b),
        .dout_b (dout_b)
    );

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Randomized and directed bench for lcd_text_ctrl against a screen-level model
// (a 64-byte array plus a cursor, scrolled by shifting whole rows).
`timescale 1ns/1ps
module tb_lcd_text_ctrl;
    import lcd_text_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic [5:0] disp_addr = 6'd0;
    logic [7:0] disp_data;
    logic       ch_valid  = 1'b0;
    logic [7:0] ch_data   = 8'h00;
    logic       ch_ready;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;
    state_t     dbg_state;

    lcd_text_ctrl #(.FILL_CHAR(8'h20), .INIT_CLEAR(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // scoreboard / reference model
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_ram [64];
    int         m_row = 0;
    int         m_col = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_ram[i] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < 48; i++) m_ram[i] = m_ram[i + 16];
        for (int i = 48; i < 64; i++) m_ram[i] = 8'h20;
    endtask

    // Applies one accepted byte to the screen model; returns expected busy length.
    task automatic model_apply(input logic [7:0] b, output int exp_busy);
        exp_busy = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_ram[m_row * 16 + m_col] = b;
            if (m_col < 15) m_col++;
            else begin
                m_col = 0;
                if (m_row < 3) m_row++;
                else begin model_scroll(); exp_busy = 112; end
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            if (m_row < 3) m_row++;
            else begin model_scroll(); exp_busy = 112; end
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_ram[m_row * 16 + m_col] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            model_clear();
            exp_busy = 64;
        end
    endtask

    // Called at a negedge; counts consecutive busy cycles (bounded).
    task automatic wait_busy(input int exp);
        int n = 0;
        if (busy) check_eq("ready_while_busy", ch_ready, 0);
        while (busy && n < 400) begin
            n++;
            @(negedge clk);
        end
        check_eq("busy_len", n, exp);
    endtask

    task automatic check_cursor(input string tag);
        check_eq({tag, "_row"}, cursor_row, m_row);
        check_eq({tag, "_col"}, cursor_col, m_col);
    endtask

    // driver: offer one byte, wait for acceptance, then let any sequence finish
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        int eb;
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = b;
        while (!ch_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        check_eq("ready_wait", ch_ready, 1);
        @(posedge clk);
        model_apply(b, eb);
        #1 ch_valid = 1'b0;
        @(negedge clk);
        wait_busy(eb);
        check_cursor("cursor");
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Reads the whole RAM through the display port, one address per cycle.
    task automatic check_ram();
        @(negedge clk);
        disp_addr = 6'd0;
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            check_eq($sformatf("ram[%0d]", a), disp_data, m_ram[a]);
            if (a < 63) disp_addr = 6'(a + 1);
        end
    endtask

    initial begin
        int eb;
        int nwr;
        int guard;
        logic [7:0] b;
        int r;

        // reset with init clear
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_disp_data", disp_data, 8'h00);
        check_eq("rst_row", cursor_row, 0);
        check_eq("rst_col", cursor_col, 0);
        rst = 1'b0;
        wait_busy(64);
        model_clear();
        check_cursor("after_init");
        check_ram();

        send_str("HELLO");
        check_ram();

        send_byte(8'h0C);
        for (int i = 0; i < 16; i++) send_byte(8'h41);
        send_byte(8'h42);
        check_ram();

        // fill three rows, row 3 partially, back to (3,0), then LF with 'Z' held behind it
        send_byte(8'h0C);
        for (int i = 0; i < 16; i++) send_byte(8'h61);
        for (int i = 0; i < 16; i++) send_byte(8'h62);
        for (int i = 0; i < 16; i++) send_byte(8'h63);
        for (int i = 0; i < 15; i++) send_byte(8'h64);
        send_byte(8'h0D);
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'h0A;
        @(posedge clk);
        model_apply(8'h0A, eb);
        #1 ch_data = 8'h5A;
        @(negedge clk);
        wait_busy(eb);
        @(posedge clk);
        model_apply(8'h5A, eb);
        #1 ch_valid = 1'b0;
        @(negedge clk);
        check_cursor("held_z");
        check_ram();

        // backspace cases
        send_byte(8'h0C);
        send_str("abc");
        send_byte(8'h08);
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(8'h08);
        check_ram();

        // reset in the middle of a scroll
        for (int i = 0; i < 3; i++) send_byte(8'h0A);
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'h0A;
        @(posedge clk);
        #1 ch_valid = 1'b0;
        nwr = 0;
        guard = 0;
        @(negedge clk);
        while (guard < 300) begin
            if (dbg_state == ST_SCR_WR) begin
                nwr++;
                if (nwr == 40) break;
            end
            guard++;
            @(negedge clk);
        end
        check_eq("scr_wr_reached", nwr, 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_state", dbg_state, ST_CLEAR);
        check_eq("rst_mid_row", cursor_row, 0);
        check_eq("rst_mid_col", cursor_col, 0);
        check_eq("rst_mid_busy", busy, 1);
        wait_busy(64);
        model_clear();
        send_byte(8'h07);
        check_ram();

        // randomized stream
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 78) b = 8'h0D;
            else if (r < 88) b = 8'h0A;
            else if (r < 95) b = 8'h08;
            else if (r < 97) b = 8'h0C;
            else             b = 8'($urandom_range(127, 255));
            send_byte(b);
            if (k % 60 == 59) check_ram();
        end
        check_ram();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_text_ctrl.md
Name: lcd_text_ctrl

Overview:
Owns the 64-byte character RAM that the ST7920 refresher reads (4 rows x 16 columns, address = row*16 + col). It turns a valid/ready character stream into RAM writes and keeps a cursor. It handles CR, LF, backspace and form-feed, and runs multi-cycle clear and scroll-up sequences. The display refresher reads through a dedicated read port that never stalls.

Parameters:
FILL_CHAR, 8'h20, byte written by clear, scroll-blank and backspace
INIT_CLEAR, 1, 1 = run a full clear after reset; 0 = enter IDLE directly with RAM contents undefined

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
disp_addr  in  6  display refresher read address
disp_data  out  8  RAM byte at disp_addr, registered, 1-cycle latency
ch_valid  in  1  character/control byte offered
ch_data  in  8  byte value
ch_ready  out  1  high only in IDLE; transfer occurs when ch_valid && ch_ready
cursor_row  out  2  current cursor row
cursor_col  out  4  current cursor column
busy  out  1  high in CLEAR, SCR_RD, SCR_WR and SCR_BLANK

Behaviour:
- Reset values:
  - disp_data=8'h00, cursor_row=0, cursor_col=0.
  - State = CLEAR if INIT_CLEAR else IDLE; ch_ready=!busy.
  - Reset mid-clear or mid-scroll aborts the sequence immediately and restarts from that reset state.
- Display port: disp_data <= ram[disp_addr] every cycle, independent of the FSM.
  - A same-cycle write to the same address returns the old data.
- States: IDLE, CLEAR, SCR_RD, SCR_WR, SCR_BLANK. Internal 6-bit index idx.
- IDLE, on transfer:
  - Printable (0x20-0x7E): write ch_data to ram[row*16+col] in the transfer cycle.
    - If col<15: col+1.
    - If col==15 and row<3: col=0, row+1.
    - If col==15 and row==3: col=0, go to SCR_RD with idx=16.
  - 0x0D CR: col=0.
  - 0x0A LF: col=0.
    - If row<3: row+1.
    - If row==3: go to SCR_RD with idx=16.
  - 0x08 BS:
    - If col>0: col-1 and write FILL_CHAR at the new position in the same cycle.
    - If col==0: no-op; the cursor never moves back to the previous row.
  - 0x0C FF: go to CLEAR with idx=0; the cursor is set to (0,0) on entry.
  - Any other byte is consumed and ignored.
- CLEAR: write FILL_CHAR to ram[idx], idx+1; on idx==63 go to IDLE. Exactly 64 cycles.
- Scroll:
  - SCR_RD: issue internal read of ram[idx].
  - SCR_WR: write the read byte to ram[idx-16], idx+1.
    - If idx was 63: idx=48 and go to SCR_BLANK.
    - Otherwise return to SCR_RD.
    - The copy takes 96 cycles.
  - SCR_BLANK: write FILL_CHAR to ram[idx], idx+1; on idx==63 go to IDLE. 16 cycles.
  - Total busy time is 112 cycles; the cursor stays at (3,0).
- ch_ready is combinational: state==IDLE. A producer holding ch_valid while busy stalls; no byte is dropped or duplicated.
- Arithmetic: row/col wrap by explicit compare, never by overflow. The address is concatenated {row,col}.

Decomposition:
- Package lcd_text_pkg holds:
  - Geometry constants: COLS=16, ROWS=4, RAM_DEPTH=64.
  - ASCII constants: CR, LF, BS, FF, SPACE.
  - FSM state encoding.
  - Shared with the LCD refresher, which needs the same geometry.
- One sub-module, text_ram_dp: 64x8 dual-port RAM.
  - Port A: read-only, registered.
  - Port B: read/write, registered read, read-old-on-write.
  - Written to infer M9K block RAM.

Test Plan:
- Reset with INIT_CLEAR=1:
  - busy=1 and ch_ready=0 for exactly 64 cycles.
  - After that, reading disp_addr 0..63 returns 8'h20 everywhere and cursor=(0,0).
- Send "HELLO" (0x48 0x45 0x4C 0x4C 0x4F):
  - ram[0..4] = those bytes, cursor=(0,5).
  - disp_addr=2 yields 8'h4C one cycle later.
- Send 16 x 'A' then 'B':
  - ram[0..15]=0x41, ram[16]=0x42, cursor=(1,1).
- Fill rows 0-3 with 'a','b','c','d', cursor at (3,0) with no scroll yet, then send LF:
  - busy for 112 cycles.
  - Afterwards rows 0-2 = 'b','c','d', row 3 = 0x20, cursor=(3,0).
  - ch_valid held throughout with 'Z': 'Z' lands at ram[48] only after busy falls.
- Cursor (0,3) then BS: ram[2]=0x20, cursor=(0,2). Cursor (1,0) then BS: no write, cursor unchanged.
- Assert rst at SCR_WR cycle 40:
  - The next cycle shows state CLEAR, cursor (0,0), busy=1.
  - A full 64-cycle clear completes.
  - An unsupported byte 0x07 sent in IDLE is accepted with RAM and cursor unchanged.
